// File: rtl/shift_register_pkg.sv
// Shared types for multi_shift_register: opcode and FSM state enums,
// plus plain opcode constants for benches that drive the raw 3-bit port.
// Optional feature macro: SHIFT_REG_ARITH_EN (SRA / ROR / ROL).
package shift_register_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'b000,
      OP_SRL   = 3'b001,
      OP_SLL   = 3'b010,
      OP_SRA   = 3'b011,
      OP_ROR   = 3'b100,
      OP_ROL   = 3'b101,
      OP_LOAD  = 3'b110,
      OP_CLEAR = 3'b111
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [2:0] OPC_NOP   = 3'b000;
   localparam logic [2:0] OPC_SRL   = 3'b001;
   localparam logic [2:0] OPC_SLL   = 3'b010;
   localparam logic [2:0] OPC_SRA   = 3'b011;
   localparam logic [2:0] OPC_ROR   = 3'b100;
   localparam logic [2:0] OPC_ROL   = 3'b101;
   localparam logic [2:0] OPC_LOAD  = 3'b110;
   localparam logic [2:0] OPC_CLEAR = 3'b111;

endpackage

// File: rtl/multi_shift_register_shift_step.sv
// shift_step: combinational network moving q by s positions (1..STEP)
// for the selected op, and reporting the last bit pushed out.
// SRA / ROR / ROL paths exist only when SHIFT_REG_ARITH_EN is defined.
module shift_step
   import shift_register_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] q,
   input  logic [AMT_W-1:0] s,
   input  op_e              op,
   input  logic             fill,
   output logic [WIDTH-1:0] q_next,
   output logic             out_bit
);

   logic [WIDTH-1:0] fill_vec;
   logic [WIDTH-1:0] lo_mask;
   logic [WIDTH-1:0] hi_mask;
   logic [WIDTH-1:0] r_probe;
   logic [WIDTH-1:0] l_probe;

   // Shift/rotate by s; the exiting bit is q[s-1] (right) or q[WIDTH-s] (left)
   always_comb begin
      fill_vec = {WIDTH{fill}};
      lo_mask  = ~({WIDTH{1'b1}} << s);
      hi_mask  = ~({WIDTH{1'b1}} >> s);
      r_probe  = q >> (s - AMT_W'(1));
      l_probe  = q << (s - AMT_W'(1));
      q_next   = q;
      out_bit  = 1'b0;
      case (op)
         OP_SRL: begin
            q_next  = (q >> s) | (fill_vec & hi_mask);
            out_bit = r_probe[0];
         end
         OP_SLL: begin
            q_next  = (q << s) | (fill_vec & lo_mask);
            out_bit = l_probe[WIDTH-1];
         end
`ifdef SHIFT_REG_ARITH_EN
         OP_SRA: begin
            q_next  = (q >> s) | ({WIDTH{q[WIDTH-1]}} & hi_mask);
            out_bit = r_probe[0];
         end
         OP_ROR: begin
            q_next  = (q >> s) | (q << (AMT_W'(WIDTH) - s));
            out_bit = r_probe[0];
         end
         OP_ROL: begin
            q_next  = (q << s) | (q >> (AMT_W'(WIDTH) - s));
            out_bit = l_probe[WIDTH-1];
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/multi_shift_register.sv
// multi_shift_register: handshaked command-driven shift register.
// LOAD/CLEAR/NOP and zero-distance shifts finish at acceptance; shifts
// run for ceil(amt/STEP) cycles in RUN. done pulses once per command.
// Optional feature macro: SHIFT_REG_ARITH_EN (SRA / ROR / ROL); when
// undefined those opcodes complete as NOP.
module multi_shift_register
   import shift_register_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned STEP  = 1,
   localparam int unsigned AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] d_in,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q_out,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   state_e           state, state_nxt;
   op_e              acc_op, run_op;
   logic [AMT_W-1:0] eff_amt, remaining, step_s;
   logic [WIDTH-1:0] q, step_q;
   logic             step_out, accept, is_shift, shift_start;
   logic             sout_r, done_r;

   // Decode the offered command: effective distance and whether it runs
   always_comb begin
      acc_op   = op_e'(cmd_op);
      eff_amt  = '0;
      is_shift = 1'b0;
      case (acc_op)
         OP_SRL, OP_SLL: begin
            is_shift = 1'b1;
            eff_amt  = (cmd_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : cmd_amt;
         end
`ifdef SHIFT_REG_ARITH_EN
         OP_SRA: begin
            is_shift = 1'b1;
            eff_amt  = (cmd_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : cmd_amt;
         end
         OP_ROR, OP_ROL: begin
            is_shift = 1'b1;
            eff_amt  = cmd_amt % AMT_W'(WIDTH);
         end
`endif
         default: ;
      endcase
      accept      = cmd_valid && (state == IDLE);
      shift_start = accept && is_shift && (eff_amt != '0);
      step_s      = (remaining > AMT_W'(STEP)) ? AMT_W'(STEP) : remaining;
   end

   // Next-state logic: enter RUN for real shifts, leave on the last step
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (shift_start) state_nxt = RUN;
         RUN:     if (remaining == step_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath: register contents, step counter, serial_out and done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         q         <= '0;
         sout_r    <= 1'b0;
         done_r    <= 1'b0;
         remaining <= '0;
         run_op    <= OP_NOP;
      end else begin
         done_r <= 1'b0;
         if (state == RUN) begin
            q         <= step_q;
            sout_r    <= step_out;
            remaining <= remaining - step_s;
            if (remaining == step_s) done_r <= 1'b1;
         end else if (accept) begin
            if (shift_start) begin
               run_op    <= acc_op;
               remaining <= eff_amt;
            end else begin
               done_r <= 1'b1;
               if (acc_op == OP_LOAD)       q <= d_in;
               else if (acc_op == OP_CLEAR) q <= '0;
            end
         end
      end
   end

   shift_step #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_step (
      .q       (q),
      .s       (step_s),
      .op      (run_op),
      .fill    (serial_in),
      .q_next  (step_q),
      .out_bit (step_out)
   );

   assign q_out      = q;
   assign serial_out = sout_r;
   assign done       = done_r;
   assign busy       = (state == RUN);
   assign cmd_ready  = (state == IDLE);

endmodule

// File: tb/tb_multi_shift_register.sv
// Scoreboard bench for multi_shift_register (WIDTH=8, STEP=3).
// Expected results come from a bit-level reference model; a monitor
// compares on every done pulse. Honours SHIFT_REG_ARITH_EN like the RTL.
module tb_multi_shift_register;
   import shift_register_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned STEP  = 3;
   localparam int unsigned AMT_W = $clog2(WIDTH) + 1;

   logic             clk, rst, cmd_valid, cmd_ready, serial_in;
   logic             serial_out, busy, done;
   logic [2:0]       cmd_op;
   logic [AMT_W-1:0] cmd_amt;
   logic [WIDTH-1:0] d_in, q_out;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             sout;
      int unsigned      busy;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [WIDTH-1:0] mq = '0;
   logic             msout = 1'b0;

   multi_shift_register #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_amt    (cmd_amt),
      .d_in       (d_in),
      .serial_in  (serial_in),
      .q_out      (q_out),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: whole-command result built bit by bit; returns RUN cycles
   function automatic int unsigned model(input logic [2:0] op, input int unsigned amt,
                                         input logic [WIDTH-1:0] d, input logic fill);
      logic [WIDTH-1:0] old;
      int unsigned      n;
      old = mq;
      n   = 0;
      case (op)
         OPC_LOAD:        mq = d;
         OPC_CLEAR:       mq = '0;
         OPC_SRL, OPC_SLL: n = (amt > WIDTH) ? WIDTH : amt;
`ifdef SHIFT_REG_ARITH_EN
         OPC_SRA:          n = (amt > WIDTH) ? WIDTH : amt;
         OPC_ROR, OPC_ROL: n = amt % WIDTH;
`endif
         default: ;
      endcase
      if (n == 0) return 0;
      for (int i = 0; i < WIDTH; i++) begin
         case (op)
            OPC_SRL: mq[i] = (i + n < WIDTH) ? old[i + n] : fill;
            OPC_SLL: mq[i] = (i >= n) ? old[i - n] : fill;
            OPC_SRA: mq[i] = (i + n < WIDTH) ? old[i + n] : old[WIDTH-1];
            OPC_ROR: mq[i] = old[(i + n) % WIDTH];
            OPC_ROL: mq[i] = old[(i + WIDTH - n) % WIDTH];
            default: ;
         endcase
      end
      msout = (op == OPC_SLL || op == OPC_ROL) ? old[WIDTH - n] : old[n - 1];
      return (n + STEP - 1) / STEP;
   endfunction

   // Issue one command; during RUN keep offering a LOAD that must be ignored
   task automatic issue(input logic [2:0] op, input int unsigned amt,
                        input logic [WIDTH-1:0] d, input logic fill);
      int unsigned k;
      exp_t e;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_amt   = AMT_W'(amt);
      d_in      = d;
      serial_in = fill;
      k = model(op, amt, d, fill);
      e.q = mq; e.sout = msout; e.busy = k;
      sb.push_back(e);
      @(posedge clk);
      repeat (k) begin
         @(negedge clk);
         cmd_valid = 1'b1;
         cmd_op    = OPC_LOAD;
         cmd_amt   = AMT_W'($urandom_range(0, 15));
         d_in      = WIDTH'($urandom);
         @(posedge clk);
      end
   endtask

   // Monitor: count busy cycles, compare against the scoreboard on each done
   initial begin
      int unsigned cnt;
      exp_t e;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            cnt = 0;
         end else begin
            if (busy) cnt++;
            if (done) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_done: got done=1 expected no pending command at %0t", $time);
               end else begin
                  e = sb.pop_front();
                  check("q_out", 32'(q_out), 32'(e.q));
                  check("serial_out", 32'(serial_out), 32'(e.sout));
                  check("busy_cycles", cnt, e.busy);
               end
               cnt = 0;
            end
         end
      end
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_amt = '0; d_in = '0; serial_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_q_out", 32'(q_out), 0);
      check("rst_serial_out", 32'(serial_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      rst = 1'b0;

      // SRL with fill
      issue(OPC_LOAD, 0, 8'h81, 1'b0);
      issue(OPC_SRL, 3, 8'h00, 1'b1);
      // SRA then ROL by 9 (mod 8 = 1)
      issue(OPC_LOAD, 0, 8'h80, 1'b0);
      issue(OPC_SRA, 2, 8'h00, 1'b0);
      issue(OPC_ROL, 9, 8'h00, 1'b0);
      // Multi-step and clamping
      issue(OPC_LOAD, 0, 8'hFF, 1'b0);
      issue(OPC_SLL, 7, 8'h00, 1'b0);
      issue(OPC_SRL, 15, 8'h00, 1'b0);
      // Back-to-back single-cycle ops
      issue(OPC_LOAD, 0, 8'h3C, 1'b0);
      issue(OPC_CLEAR, 0, 8'h55, 1'b0);
      issue(OPC_NOP, 0, 8'hAA, 1'b0);
      // Zero-distance shift, rotate by exactly WIDTH
      issue(OPC_LOAD, 0, 8'h96, 1'b0);
      issue(OPC_SRL, 0, 8'h00, 1'b1);
      issue(OPC_ROR, 8, 8'h00, 1'b1);
      issue(OPC_ROR, 3, 8'h00, 1'b0);

      // Reset in the middle of a run: no done, clean idle state
      issue(OPC_LOAD, 0, 8'hA5, 1'b0);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OPC_SRL; cmd_amt = AMT_W'(8); serial_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mq = '0; msout = 1'b0;
      check("midrun_q_out", 32'(q_out), 0);
      check("midrun_serial_out", 32'(serial_out), 0);
      check("midrun_busy", 32'(busy), 0);
      check("midrun_done", 32'(done), 0);
      check("midrun_cmd_ready", 32'(cmd_ready), 1);
      @(negedge clk);
      check("midrun_no_late_done", 32'(done), 0);

      // Randomised command stream
      for (int i = 0; i < 250; i++) begin
         issue(3'($urandom_range(0, 7)), $urandom_range(0, 15),
               WIDTH'($urandom), 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
